// File: rtl/hamming_secded_dec.sv
// Pipelined SECDED Hamming decoder with valid/ready handshake on both sides.
// Define HAMMING_DEC_STATS_EN to add saturating SEC/DED word counters.
module hamming_secded_dec #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P_W = (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 :
                       (DATA_W <= 57) ? 6 : 7,
  localparam int CW_W = DATA_W + P_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CW_W-1:0]   i_code,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [P_W-1:0]    o_syndrome,
  output logic              o_err_sec,
`ifdef HAMMING_DEC_STATS_EN
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_sec_cnt,
  output logic [CNT_W-1:0]  o_ded_cnt,
`endif
  output logic              o_err_ded
);

  localparam logic [P_W-1:0] MAX_POS = P_W'(CW_W - 1);

  function automatic logic [CW_W-1:0] pmask(input int j);
    logic [CW_W-1:0] m;
    m = '0;
    for (int k = 1; k < CW_W; k++)
      if (((k >> j) & 1) == 1)
        m = m | (CW_W'(1) << (k - 1));
    return m;
  endfunction

  function automatic int dpos(input int i);
    int n;
    int r;
    n = 0;
    r = 1;
    for (int k = 1; k < CW_W; k++)
      if ((k & (k - 1)) != 0) begin
        if (n == i) r = k;
        n = n + 1;
      end
    return r;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [CW_W-1:0]   s1_code_q, s1_code_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [P_W-1:0]    syn_q, syn_d;
  logic              sec_q, sec_d;
  logic              ded_q, ded_d;

  logic              s2_adv;
  logic [P_W-1:0]    syn_c;
  logic [CW_W-1:0]   fix_c;
  logic [DATA_W-1:0] dat_c;
  logic              in_rng, flip_c;

  for (genvar j = 0; j < P_W; j++) begin : g_syn
    assign syn_c[j] = ^(i_code & pmask(j));
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_dat
    assign dat_c[i] = fix_c[dpos(i) - 1];
  end

  always_comb begin
    in_rng = (s1_syn_q <= MAX_POS);
    flip_c = s1_par_q & in_rng & (s1_syn_q != '0);
    fix_c  = s1_code_q;
    if (flip_c)
      fix_c = s1_code_q ^ (CW_W'(1) << (s1_syn_q - P_W'(1)));
  end

  always_comb begin
    s2_adv  = !s2_valid_q | i_ready;
    o_ready = !s1_valid_q | s2_adv;

    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (o_ready) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_code_d = i_code;
        s1_syn_d  = syn_c;
        s1_par_d  = ^i_code;
      end
    end

    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    syn_d      = syn_q;
    sec_d      = sec_q;
    ded_d      = ded_q;
    // Output registers only reload when a word moves in, so they hold while stalled.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d = dat_c;
        syn_d  = s1_syn_q;
        sec_d  = s1_par_q & in_rng;
        ded_d  = s1_par_q ? !in_rng : (s1_syn_q != '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      syn_q      <= '0;
      sec_q      <= 1'b0;
      ded_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      syn_q      <= syn_d;
      sec_q      <= sec_d;
      ded_q      <= ded_d;
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_data     = data_q;
  assign o_syndrome = syn_q;
  assign o_err_sec  = sec_q;
  assign o_err_ded  = ded_q;

`ifdef HAMMING_DEC_STATS_EN
  logic             out_fire;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  // Clear has priority over a coincident increment.
  always_comb begin
    out_fire  = s2_valid_q & i_ready;
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (i_cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (out_fire & sec_q & ~&sec_cnt_q)
        sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_fire & ded_q & ~&ded_cnt_q)
        ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign o_sec_cnt = sec_cnt_q;
  assign o_ded_cnt = ded_cnt_q;
`endif

endmodule
